// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file: merges single-cycle ALU results with
// load returns buffered in a 2-entry in-order FIFO, drops x0 writes, bounds load starvation.
module regfile_wb_arbiter #(
    parameter int SIZE       = 32,
    parameter int MEM_DEPTH  = 32,
    parameter int STARVE_MAX = 4,
    localparam int AW        = $clog2(MEM_DEPTH)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [SIZE-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [AW-1:0]   ld_rd,
    input  logic [SIZE-1:0] ld_data,
    output logic            wren,
    output logic [AW-1:0]   write_reg,
    output logic [SIZE-1:0] write_data,
    output logic [1:0]      ld_count
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    logic [AW-1:0]   fifo_rd   [2];
    logic [SIZE-1:0] fifo_data [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count;
    logic [SW-1:0]   starve;

    logic fifo_nonempty;
    logic load_forced;
    logic alu_win;
    logic ld_pop;
    logic ld_push;
    logic [AW-1:0]   head_rd;
    logic [SIZE-1:0] head_data;

    assign fifo_nonempty = (count != 2'd0);
    assign load_forced   = fifo_nonempty && (starve == STARVE_TOP);
    assign alu_ready     = alu_valid && !load_forced;
    assign alu_win       = alu_ready;
    // Pop decision uses registered occupancy, so a fresh push waits at least one cycle.
    assign ld_pop        = fifo_nonempty && !alu_win;
    assign ld_ready      = (count != 2'd2);
    assign ld_push       = ld_valid && ld_ready;
    assign head_rd       = fifo_rd[rd_ptr];
    assign head_data     = fifo_data[rd_ptr];
    assign ld_count      = count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_rd[i]   <= '0;
                fifo_data[i] <= '0;
            end
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            starve     <= '0;
            wren       <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            if (ld_push) begin
                fifo_rd[wr_ptr]   <= ld_rd;
                fifo_data[wr_ptr] <= ld_data;
                wr_ptr            <= ~wr_ptr;
            end
            if (ld_pop) begin
                rd_ptr <= ~rd_ptr;
            end

            case ({ld_push, ld_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            if (ld_pop || !fifo_nonempty) begin
                starve <= '0;
            end else if (alu_win && (starve != STARVE_TOP)) begin
                starve <= starve + SW'(1);
            end

            // x0 winners complete their transfer but leave the write port idle.
            if (alu_win) begin
                wren <= (alu_rd != '0);
                if (alu_rd != '0) begin
                    write_reg  <= alu_rd;
                    write_data <= alu_data;
                end
            end else if (ld_pop) begin
                wren <= (head_rd != '0);
                if (head_rd != '0) begin
                    write_reg  <= head_rd;
                    write_data <= head_data;
                end
            end else begin
                wren <= 1'b0;
            end
        end
    end

endmodule
